// File: rtl/sdram_cache_if.sv
// Word-addressed request/response bus used on both sides of sdram_cache.
//   addr  : word address [24:2]
//   din   : write data, master to slave
//   dout  : read data, slave to master
//   lane  : byte enables, bit n = byte n
//   wr    : 1 = write, 0 = read
//   valid : request, held by the master until ready
//   ready : one-cycle completion pulse from the slave
// The master modport is the requesting side.
interface sdram_cache_if;
  logic [24:2] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [3:0]  lane;
  logic        wr;
  logic        valid;
  logic        ready;

  modport master (output addr, din, lane, wr, valid, input dout, ready);
  modport slave  (input addr, din, lane, wr, valid, output dout, ready);
endinterface

// File: rtl/sdram_cache.sv
// Direct-mapped, write-through, single-word-line cache between the CPU bus
// and the CPU port of the SDRAM controller. Read hits complete locally;
// read misses and all writes go to the controller. Writes never allocate.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   cpu          : CPU side bus (this block is the slave)
//   mem          : SDRAM controller side bus (this block is the master)
//   flush        : pulse, invalidates every line
//   flush_busy   : flush requested and not yet applied
//
// state   | meaning
// S_IDLE  | service pending flush, else accept a CPU request
// S_MISS  | read forwarded to SDRAM, waiting for mem.ready
// S_WRITE | write forwarded to SDRAM, waiting for mem.ready
// S_DONE  | cpu.ready cycle; CPU drops cpu.valid here
module sdram_cache #(
  parameter int INDEX_BITS = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  sdram_cache_if.slave  cpu,
  sdram_cache_if.master mem,
  input  logic          flush,
  output logic          flush_busy
);
  localparam int TAG_BITS = 23 - INDEX_BITS;
  localparam int LINES    = 2 ** INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_MISS, S_WRITE, S_DONE} state_t;

  state_t                state;
  logic                  req;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];

  logic [INDEX_BITS-1:0] idx_c, idx_m;
  logic [TAG_BITS-1:0]   tag_c, tag_m;
  logic                  hit, wr_hit;

  assign idx_c  = cpu.addr[INDEX_BITS+1:2];
  assign tag_c  = cpu.addr[24:INDEX_BITS+2];
  assign idx_m  = mem.addr[INDEX_BITS+1:2];
  assign tag_m  = mem.addr[24:INDEX_BITS+2];
  assign hit    = valid[idx_c] & (tag_mem[idx_c] == tag_c);
  assign wr_hit = valid[idx_m] & (tag_mem[idx_m] == tag_m);

  // The controller returns to idle in the cycle it pulses ready, so valid
  // must already be low in that cycle or it would start a second access.
  assign mem.valid = req & ~mem.ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      req        <= 1'b0;
      valid      <= '0;
      flush_busy <= 1'b0;
      cpu.ready  <= 1'b0;
      cpu.dout   <= '0;
      mem.addr   <= '0;
      mem.din    <= '0;
      mem.lane   <= '0;
      mem.wr     <= 1'b0;
    end else begin
      cpu.ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush_busy) begin
            valid      <= '0;
            flush_busy <= 1'b0;
          end else if (!flush && cpu.valid) begin
            // A flush arriving now is taken first; the request waits.
            if (!cpu.wr && hit) begin
              cpu.dout  <= data_mem[idx_c];
              cpu.ready <= 1'b1;
              state     <= S_DONE;
            end else if (!cpu.wr) begin
              mem.addr <= cpu.addr;
              mem.wr   <= 1'b0;
              mem.lane <= 4'hF;
              req      <= 1'b1;
              state    <= S_MISS;
            end else begin
              mem.addr <= cpu.addr;
              mem.din  <= cpu.din;
              mem.lane <= cpu.lane;
              mem.wr   <= 1'b1;
              req      <= 1'b1;
              state    <= S_WRITE;
            end
          end
        end
        S_MISS: begin
          if (mem.ready) begin
            valid[idx_m] <= 1'b1;
            cpu.dout     <= mem.dout;
            cpu.ready    <= 1'b1;
            req          <= 1'b0;
            state        <= S_DONE;
          end
        end
        S_WRITE: begin
          if (mem.ready) begin
            cpu.ready <= 1'b1;
            req       <= 1'b0;
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Placed last so a new pulse survives a flush being applied now.
      if (flush) flush_busy <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (state == S_MISS && mem.ready) begin
      tag_mem[idx_m]  <= tag_m;
      data_mem[idx_m] <= mem.dout;
    end else if (state == S_WRITE && mem.ready && wr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (mem.lane[b]) data_mem[idx_m][8*b +: 8] <= mem.din[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_sdram_cache.sv
module tb_sdram_cache;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic flush_busy;

  sdram_cache_if cpu_bus ();
  sdram_cache_if mem_bus ();

  sdram_cache #(.INDEX_BITS(6)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu        (cpu_bus),
    .mem        (mem_bus),
    .flush      (flush),
    .flush_busy (flush_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard of CPU completions, pushed at request time.
  typedef struct {
    logic        wr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  // SDRAM controller model: accepts when idle and valid, answers after lat
  // cycles with a one-cycle ready pulse, then is idle again immediately.
  int          lat = 2;
  int          cnt = 0;
  bit          busy = 0;
  int          req_count = 0;
  logic [31:0] mem_rdata = '0;
  logic [22:0] rec_addr;
  logic [31:0] rec_din;
  logic [3:0]  rec_lane;
  logic        rec_wr;

  initial begin
    mem_bus.ready = 1'b0;
    mem_bus.dout  = '0;
    cpu_bus.valid = 1'b0;
    cpu_bus.wr    = 1'b0;
    cpu_bus.addr  = '0;
    cpu_bus.din   = '0;
    cpu_bus.lane  = '0;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      busy          = 0;
      mem_bus.ready = 1'b0;
    end else if (mem_bus.ready) begin
      mem_bus.ready = 1'b0;
      busy          = 0;
    end else if (busy) begin
      if (cnt == 0) begin
        check("mem_addr_stable", 32'(mem_bus.addr), 32'(rec_addr));
        check("mem_din_stable",  mem_bus.din, rec_din);
        check("mem_lane_stable", 32'(mem_bus.lane), 32'(rec_lane));
        mem_bus.dout  = rec_wr ? 32'h0 : mem_rdata;
        mem_bus.ready = 1'b1;
      end else begin
        cnt--;
      end
    end else if (mem_bus.valid) begin
      busy     = 1;
      cnt      = lat;
      req_count++;
      rec_addr = mem_bus.addr;
      rec_din  = mem_bus.din;
      rec_lane = mem_bus.lane;
      rec_wr   = mem_bus.wr;
    end
  end

  // mem.valid must be low whenever the controller's ready pulse is visible.
  always @(negedge clk) begin
    #2;
    if (reset_n && mem_bus.ready) check("valid_during_ready", 32'(mem_bus.valid), 32'd0);
  end

  always @(negedge clk) begin
    if (reset_n && cpu_bus.ready) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (!e.wr) check("cpu_dout", cpu_bus.dout, e.data);
      end
    end
  end

  task automatic do_access(input string nm, input logic [22:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] l,
                           input logic [31:0] exp, input bit miss);
    int start_req;
    int cyc;
    exp_t e;
    @(negedge clk);
    start_req     = req_count;
    cpu_bus.addr  = a;
    cpu_bus.wr    = w;
    cpu_bus.din   = d;
    cpu_bus.lane  = l;
    cpu_bus.valid = 1'b1;
    e.wr = w;
    e.data = exp;
    sb.push_back(e);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cpu_bus.ready && cyc < 50);
    if (!cpu_bus.ready) check({nm, "_timeout"}, 32'd0, 32'd1);
    cpu_bus.valid = 1'b0;
    check({nm, "_mem_reqs"}, 32'(req_count - start_req), miss ? 32'd1 : 32'd0);
    if (!miss) check({nm, "_hit_latency"}, 32'(cyc), 32'd1);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_cpu_ready"},  32'(cpu_bus.ready), 32'd0);
    check({nm, "_cpu_dout"},   cpu_bus.dout, 32'd0);
    check({nm, "_flush_busy"}, 32'(flush_busy), 32'd0);
    check({nm, "_mem_valid"},  32'(mem_bus.valid), 32'd0);
    check({nm, "_mem_wr"},     32'(mem_bus.wr), 32'd0);
    check({nm, "_mem_lane"},   32'(mem_bus.lane), 32'd0);
    check({nm, "_mem_addr"},   32'(mem_bus.addr), 32'd0);
    check({nm, "_mem_din"},    mem_bus.din, 32'd0);
  endtask

  initial begin
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Cold read miss.
    mem_rdata = 32'hDEADBEEF;
    do_access("cold_read", 23'h000010, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF, 1);
    check("cold_mem_addr", 32'(rec_addr), 32'h10);
    check("cold_mem_wr",   32'(rec_wr), 32'd0);
    check("cold_mem_lane", 32'(rec_lane), 32'hF);

    // Read hit.
    do_access("hit_read", 23'h000010, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF, 0);

    // Byte-lane write hit, forwarded to memory and merged into the line.
    do_access("wr_hit", 23'h000010, 1'b1, 32'h11223344, 4'b0101, 32'h0, 1);
    check("wr_mem_addr", 32'(rec_addr), 32'h10);
    check("wr_mem_din",  rec_din, 32'h11223344);
    check("wr_mem_lane", 32'(rec_lane), 32'h5);
    check("wr_mem_wr",   32'(rec_wr), 32'd1);
    do_access("merged_read", 23'h000010, 1'b0, 32'h0, 4'hF, 32'hDE22BE44, 0);

    // Conflict miss on the same index replaces the line.
    mem_rdata = 32'hCAFEF00D;
    do_access("conflict_read", 23'h000050, 1'b0, 32'h0, 4'hF, 32'hCAFEF00D, 1);
    do_access("conflict_hit", 23'h000050, 1'b0, 32'h0, 4'hF, 32'hCAFEF00D, 0);
    mem_rdata = 32'h12345678;
    do_access("evicted_read", 23'h000010, 1'b0, 32'h0, 4'hF, 32'h12345678, 1);

    // Write miss does not allocate.
    do_access("wr_miss", 23'h000020, 1'b1, 32'hA5A5A5A5, 4'hF, 32'h0, 1);
    mem_rdata = 32'h0BADF00D;
    do_access("no_alloc_read", 23'h000020, 1'b0, 32'h0, 4'hF, 32'h0BADF00D, 1);

    // Flush: busy for exactly one cycle, then previously valid lines miss.
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_set", 32'(flush_busy), 32'd1);
    @(negedge clk);
    check("flush_busy_clr", 32'(flush_busy), 32'd0);
    mem_rdata = 32'h5555AAAA;
    do_access("post_flush_read", 23'h000050, 1'b0, 32'h0, 4'hF, 32'h5555AAAA, 1);
    do_access("post_flush_hit", 23'h000050, 1'b0, 32'h0, 4'hF, 32'h5555AAAA, 0);

    // Reset in the middle of a miss to another line.
    lat = 8;
    @(negedge clk);
    cpu_bus.addr  = 23'h000030;
    cpu_bus.wr    = 1'b0;
    cpu_bus.lane  = 4'hF;
    cpu_bus.valid = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_miss_mem_valid", 32'(mem_bus.valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    cpu_bus.valid = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    reset_n = 1'b1;
    lat = 2;
    mem_rdata = 32'h77778888;
    do_access("after_reset_read", 23'h000050, 1'b0, 32'h0, 4'hF, 32'h77778888, 1);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
